// File: rtl/dram_port_arbiter.sv
// Two-port round-robin arbiter in front of the single-port 24-bit data DRAM.
// It also sequences the memory-clear strobe and is the only driver of the DRAM pins.
module dram_port_arbiter #(
  parameter int AW         = 24,
  parameter int DW         = 24,
  parameter int MAX_ADDR   = 270000,
  parameter int CLR_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          mem_write,
  output logic          mem_read,
  output logic          mem_reset,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    CLEAR  = 2'd3
  } state_t;

  localparam int            CW       = 16;
  localparam logic [AW-1:0] MAX_A    = AW'(MAX_ADDR);
  localparam logic [CW-1:0] CLR_LOAD = CW'(CLR_CYCLES - 1);

  state_t        state_r, state_s;
  logic          grant_r, grant_s;
  logic          last_grant_r, last_grant_s;
  logic          acc_we_r, acc_we_s;
  logic          acc_oor_r, acc_oor_s;
  logic          clr_pend_r, clr_pend_s;
  logic [CW-1:0] clr_cnt_r, clr_cnt_s;

  logic          mem_write_s, mem_read_s, mem_reset_s, clr_busy_s;
  logic [AW-1:0] mem_addr_s;
  logic [DW-1:0] mem_wdata_s;
  logic          p0_ack_s, p1_ack_s, p0_err_s, p1_err_s;
  logic [DW-1:0] p0_rdata_s, p1_rdata_s;

  logic          win_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;
  logic          sel_oor_s;

  // Winner selection: the lone requester, otherwise the port not granted last.
  always_comb begin
    if (p0_req && p1_req) begin
      win_s = ~last_grant_r;
    end else begin
      win_s = p1_req;
    end
    sel_we_s    = win_s ? p1_we    : p0_we;
    sel_addr_s  = win_s ? p1_addr  : p0_addr;
    sel_wdata_s = win_s ? p1_wdata : p0_wdata;
    sel_oor_s   = (sel_addr_s > MAX_A);
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    last_grant_s = last_grant_r;
    acc_we_s     = acc_we_r;
    acc_oor_s    = acc_oor_r;
    clr_cnt_s    = clr_cnt_r;
    clr_pend_s   = clr_pend_r | clr_req;
    mem_write_s  = 1'b0;
    mem_read_s   = 1'b0;
    mem_reset_s  = 1'b0;
    mem_addr_s   = mem_addr;
    mem_wdata_s  = mem_wdata;
    p0_ack_s     = 1'b0;
    p1_ack_s     = 1'b0;
    p0_err_s     = 1'b0;
    p1_err_s     = 1'b0;
    p0_rdata_s   = p0_rdata;
    p1_rdata_s   = p1_rdata;

    case (state_r)
      IDLE: begin
        if (clr_pend_r || clr_req) begin
          state_s     = CLEAR;
          mem_reset_s = 1'b1;
          clr_cnt_s   = CLR_LOAD;
        end else if (p0_req || p1_req) begin
          state_s      = ACCESS;
          grant_s      = win_s;
          last_grant_s = win_s;
          acc_we_s     = sel_we_s;
          acc_oor_s    = sel_oor_s;
          mem_addr_s   = sel_addr_s;
          mem_wdata_s  = sel_wdata_s;
          mem_read_s   = ~sel_we_s & ~sel_oor_s;
          mem_write_s  = sel_we_s & ~sel_oor_s;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        state_s = RESP;
        if (grant_r) begin
          p1_ack_s = 1'b1;
          p1_err_s = acc_oor_r;
          if (acc_oor_r) begin
            p1_rdata_s = '0;
          end else if (!acc_we_r) begin
            p1_rdata_s = mem_rdata;
          end else begin
            p1_rdata_s = p1_rdata;
          end
        end else begin
          p0_ack_s = 1'b1;
          p0_err_s = acc_oor_r;
          if (acc_oor_r) begin
            p0_rdata_s = '0;
          end else if (!acc_we_r) begin
            p0_rdata_s = mem_rdata;
          end else begin
            p0_rdata_s = p0_rdata;
          end
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      CLEAR: begin
        // Pulses arriving during the clear merge into it.
        if (clr_cnt_r == '0) begin
          state_s    = IDLE;
          clr_pend_s = 1'b0;
        end else begin
          clr_cnt_s   = clr_cnt_r - 1'b1;
          mem_reset_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    clr_busy_s = clr_pend_s | (state_s == CLEAR);
  end

  // State and registered-output update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      acc_we_r     <= 1'b0;
      acc_oor_r    <= 1'b0;
      clr_pend_r   <= 1'b0;
      clr_cnt_r    <= '0;
      mem_write    <= 1'b0;
      mem_read     <= 1'b0;
      mem_reset    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      clr_busy     <= 1'b0;
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
      p0_err       <= 1'b0;
      p1_err       <= 1'b0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
      acc_we_r     <= acc_we_s;
      acc_oor_r    <= acc_oor_s;
      clr_pend_r   <= clr_pend_s;
      clr_cnt_r    <= clr_cnt_s;
      mem_write    <= mem_write_s;
      mem_read     <= mem_read_s;
      mem_reset    <= mem_reset_s;
      mem_addr     <= mem_addr_s;
      mem_wdata    <= mem_wdata_s;
      clr_busy     <= clr_busy_s;
      p0_ack       <= p0_ack_s;
      p1_ack       <= p1_ack_s;
      p0_err       <= p0_err_s;
      p1_err       <= p1_err_s;
      p0_rdata     <= p0_rdata_s;
      p1_rdata     <= p1_rdata_s;
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench for dram_port_arbiter: a behavioural DRAM, a reference memory
// for expected read data, and per-port expectation queues popped on each ack.
module tb_dram_port_arbiter;

  localparam int MAX_ADDR   = 270000;
  localparam int CLR_CYCLES = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [23:0] p0_addr = 24'h0, p0_wdata = 24'h0;
  logic        p0_ack, p0_err;
  logic [23:0] p0_rdata;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [23:0] p1_addr = 24'h0, p1_wdata = 24'h0;
  logic        p1_ack, p1_err;
  logic [23:0] p1_rdata;
  logic        clr_req = 1'b0;
  logic        clr_busy, mem_write, mem_read, mem_reset;
  logic [23:0] mem_addr, mem_wdata;
  logic [23:0] mem_rdata = 24'hEEEEEE;

  dram_port_arbiter #(.AW(24), .DW(24), .MAX_ADDR(MAX_ADDR), .CLR_CYCLES(CLR_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .mem_write(mem_write), .mem_read(mem_read), .mem_reset(mem_reset),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [23:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  int          ack_port[$];
  int          ack_cyc[$];
  logic [23:0] dram    [logic [23:0]];
  logic [23:0] ref_mem [logic [23:0]];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          strobe_cnt = 0;
  int          clr_end_cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural DRAM: writes and clear on the clock edge, combinational read.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_reset) dram.delete();
    else if (mem_write) dram[mem_addr] = mem_wdata;
  end

  always @(mem_read, mem_addr) begin
    if (!mem_read) mem_rdata = 24'hEEEEEE;
    else if (dram.exists(mem_addr)) mem_rdata = dram[mem_addr];
    else mem_rdata = 24'h000000;
  end

  // Scoreboard pop on acks plus strobe exclusivity and stray-error checks.
  always @(negedge clk) begin
    exp_t e;
    if (p0_ack) begin
      if (exp_q0.size() == 0) check_val("p0_unexpected_ack", 32'd1, 32'd0);
      else begin
        e = exp_q0.pop_front();
        if (e.rd) check_val("p0_rdata", 32'(p0_rdata), 32'(e.rdata));
        check_val("p0_err", 32'(p0_err), 32'(e.err));
      end
      ack_port.push_back(0);
      ack_cyc.push_back(cyc);
    end else if (p0_err) check_val("p0_err_stray", 32'(p0_err), 32'd0);
    if (p1_ack) begin
      if (exp_q1.size() == 0) check_val("p1_unexpected_ack", 32'd1, 32'd0);
      else begin
        e = exp_q1.pop_front();
        if (e.rd) check_val("p1_rdata", 32'(p1_rdata), 32'(e.rdata));
        check_val("p1_err", 32'(p1_err), 32'(e.err));
      end
      ack_port.push_back(1);
      ack_cyc.push_back(cyc);
    end else if (p1_err) check_val("p1_err_stray", 32'(p1_err), 32'd0);
    if (mem_read || mem_write || mem_reset)
      check_val("strobe_excl", 32'($countones({mem_read, mem_write, mem_reset})), 32'd1);
    if (mem_read || mem_write) strobe_cnt++;
  end

  task automatic do_req(input int port, input logic we, input logic [23:0] addr, input logic [23:0] wdata);
    exp_t e;
    logic got;
    e.err = (addr > 24'(MAX_ADDR));
    e.rd  = e.err | ~we;
    if (e.err || we) e.rdata = 24'h0;
    else e.rdata = ref_mem.exists(addr) ? ref_mem[addr] : 24'h0;
    if (we && !e.err) ref_mem[addr] = wdata;
    if (port == 0) begin
      exp_q0.push_back(e);
      p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
    end else begin
      exp_q1.push_back(e);
      p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = (port == 0) ? p0_ack : p1_ack;
    end
    check_val((port == 0) ? "p0_ack_timeout" : "p1_ack_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
    if (port == 0) p0_req = 1'b0;
    else p1_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int n;
    dram[24'd5]    = 24'h00ABCD;
    ref_mem[24'd5] = 24'h00ABCD;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_flags", 32'({p0_ack, p1_ack, p0_err, p1_err, mem_write, mem_read, mem_reset, clr_busy}), 32'd0);
    check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_val("rst_rdata", 32'({p0_rdata, p1_rdata} != 48'h0), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Test 2: both ports hold write requests -> strict alternation, 3 cycles apart
    fork
      begin for (int i = 0; i < 3; i++) do_req(0, 1'b1, 24'd100 + 24'(i), 24'h010000 + 24'(i)); end
      begin for (int i = 0; i < 3; i++) do_req(1, 1'b1, 24'd200 + 24'(i), 24'h020000 + 24'(i)); end
    join
    check_val("rr_count", 32'(ack_port.size()), 32'd6);
    for (int i = 0; i < 6 && i < ack_port.size(); i++) begin
      check_val("rr_port", 32'(ack_port[i]), 32'(i % 2));
      if (i > 0) check_val("rr_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
    end

    // Test 1: read latency, strobe in T+1, ack in T+2
    @(posedge clk); #1;
    do_req_t1: begin
      exp_t e;
      e.rd = 1'b1; e.rdata = ref_mem[24'd5]; e.err = 1'b0;
      exp_q0.push_back(e);
      p0_we = 1'b0; p0_addr = 24'd5; p0_req = 1'b1;
      @(negedge clk);
      check_val("t1_t0_read", 32'(mem_read), 32'd0);
      @(negedge clk);
      check_val("t1_t1_read", 32'(mem_read), 32'd1);
      check_val("t1_t1_write", 32'(mem_write), 32'd0);
      check_val("t1_t1_addr", 32'(mem_addr), 32'd5);
      @(negedge clk);
      check_val("t1_t2_ack", 32'(p0_ack), 32'd1);
      check_val("t1_t2_rdata", 32'(p0_rdata), 32'h00ABCD);
      @(posedge clk); #1;
      p0_req = 1'b0;
    end

    // Test 3 plus the MAX_ADDR boundary: write on one port, read back on the other
    do_req(1, 1'b1, 24'd9, 24'h123456);
    do_req(0, 1'b0, 24'd9, 24'h0);
    do_req(1, 1'b1, 24'(MAX_ADDR), 24'hFFFFFF);
    do_req(0, 1'b0, 24'(MAX_ADDR), 24'h0);
    do_req(0, 1'b0, 24'd9, 24'h0);
    repeat (3) @(negedge clk);
    check_val("rdata_hold", 32'(p0_rdata), 32'h123456);

    // Test 5: out-of-range accesses produce no strobe, err=1, rdata=0
    s = strobe_cnt;
    do_req(0, 1'b0, 24'd300000, 24'h0);
    do_req(1, 1'b1, 24'(MAX_ADDR + 1), 24'h555555);
    check_val("oor_no_strobe", 32'(strobe_cnt - s), 32'd0);
    check_val("oor_p0_rdata", 32'(p0_rdata), 32'd0);

    // Test 4: clear requested during a p1 access; waiting p0 read sees cleared memory
    ack_port.delete();
    ack_cyc.delete();
    fork
      do_req(1, 1'b1, 24'd20, 24'h777777);
      begin
        @(posedge clk); #1;
        clr_req = 1'b1;
        ref_mem.delete();
        @(negedge clk);
        check_val("t4_p1_in_access", 32'(mem_write), 32'd1);
        @(posedge clk); #1;
        clr_req = 1'b0;
        @(negedge clk);
        check_val("t4_busy_pending", 32'(clr_busy), 32'd1);
      end
      begin
        @(posedge clk); #2;
        do_req(0, 1'b0, 24'd9, 24'h0);
      end
      begin
        n = 0;
        for (int i = 0; i < 20 && !mem_reset; i++) @(negedge clk);
        while (mem_reset && n < 10) begin
          check_val("t4_busy_clear", 32'(clr_busy), 32'd1);
          n++;
          @(negedge clk);
        end
        check_val("t4_clear_len", 32'(n), 32'(CLR_CYCLES));
        check_val("t4_busy_done", 32'(clr_busy), 32'd0);
        clr_end_cyc = cyc;
      end
    join
    check_val("t4_ack_count", 32'(ack_port.size()), 32'd2);
    if (ack_port.size() == 2) begin
      check_val("t4_first_p1", 32'(ack_port[0]), 32'd1);
      check_val("t4_p0_after_clear", 32'(ack_cyc[1] > clr_end_cyc), 32'd1);
    end

    // Test 6: reset in the middle of a write access
    @(posedge clk); #1;
    p0_we = 1'b1; p0_addr = 24'd50; p0_wdata = 24'h0F0F0F; p0_req = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    p0_req = 1'b0;
    @(negedge clk);
    check_val("t6_in_access", 32'(mem_write), 32'd1);
    @(negedge clk);
    check_val("t6_after_rst", 32'({mem_write, mem_read, mem_reset, p0_ack, p1_ack}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    ack_port.delete();
    ack_cyc.delete();
    fork
      do_req(0, 1'b1, 24'd60, 24'h0A0A0A);
      do_req(1, 1'b1, 24'd61, 24'h0B0B0B);
    join
    check_val("t6_ack_count", 32'(ack_port.size()), 32'd2);
    if (ack_port.size() > 0) check_val("t6_first_p0", 32'(ack_port[0]), 32'd0);

    repeat (2) @(negedge clk);
    check_val("queues_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
